// File: rtl/mmio_bus_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bus_bridge_if
// Description : Bundles the CPU load/store bus, the DMEM side-band and the
//               peripheral slot bus seen by mmio_bus_bridge.
//               slave  : bridge view (CPU/DMEM/slot inputs in, strobes out)
//               master : environment view (drives CPU/DMEM/slot inputs)
//               Signals: addr, wdata, we, re, stall, rdata, dmem_we,
//               dmem_rdata, slot_we, slot_re, slot_addr, slot_wdata,
//               slot_rdata, slot_ready, bus_err, err_addr, err_clr
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_bus_bridge_if #(
    parameter int N_SLOTS = 8,
    parameter int DATA_W  = 32
);
    logic [31:0]             addr;
    logic [DATA_W-1:0]       wdata;
    logic                    we;
    logic                    re;
    logic                    stall;
    logic [DATA_W-1:0]       rdata;
    logic                    dmem_we;
    logic [DATA_W-1:0]       dmem_rdata;
    logic [N_SLOTS-1:0]      slot_we;
    logic [N_SLOTS-1:0]      slot_re;
    logic [11:0]             slot_addr;
    logic [DATA_W-1:0]       slot_wdata;
    logic [N_SLOTS*DATA_W-1:0] slot_rdata;
    logic [N_SLOTS-1:0]      slot_ready;
    logic                    bus_err;
    logic [31:0]             err_addr;
    logic                    err_clr;

    modport slave (
        input  addr, wdata, we, re, dmem_rdata, slot_rdata, slot_ready, err_clr,
        output stall, rdata, dmem_we, slot_we, slot_re, slot_addr, slot_wdata,
               bus_err, err_addr
    );

    modport master (
        output addr, wdata, we, re, dmem_rdata, slot_rdata, slot_ready, err_clr,
        input  stall, rdata, dmem_we, slot_we, slot_re, slot_addr, slot_wdata,
               bus_err, err_addr
    );
endinterface
`default_nettype wire

// File: rtl/mmio_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bus_bridge
// Description : Routes CPU loads/stores to DMEM (zero-wait, combinational) or
//               to one of N_SLOTS peripheral slots through a registered
//               strobe/ready handshake that stalls the CPU until completion.
//               Unmapped accesses (and, optionally, unresponsive slots) raise
//               a sticky bus error that records the first failing address.
// Ports       : clk, rst (sync, active-high), bus (mmio_bus_bridge_if.slave)
// Options     : MMIO_TIMEOUT_EN - when defined, a WAIT lasting TIMEOUT cycles
//               without ready is aborted as a bus error.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_bus_bridge #(
    parameter int                N_SLOTS    = 8,
    parameter int                DATA_W     = 32,
    parameter int                PERIPH_BIT = 11,
    parameter logic [11:0]       BASE_OFF   = 12'h800,
    parameter int                TIMEOUT    = 15,
    parameter logic [DATA_W-1:0] ERR_DATA   = DATA_W'(32'hDEAD_BEEF)
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mmio_bus_bridge_if.slave bus
);
    localparam int C_IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state, w_state_d;
    logic [C_IDX_W-1:0]  r_idx, w_idx_d;
    logic [31:0]         r_addr, w_addr_d;
    logic [DATA_W-1:0]   r_wdata, w_wdata_d;
    logic                r_wr, w_wr_d;
    logic [N_SLOTS-1:0]  r_slot_we, w_slot_we_d;
    logic [N_SLOTS-1:0]  r_slot_re, w_slot_re_d;
    logic [DATA_W-1:0]   r_rdata, w_rdata_d;
    logic                r_bus_err, w_bus_err_d;
    logic [31:0]         r_err_addr, w_err_addr_d;
    logic                w_stall;
    logic                w_err_evt;
    logic [31:0]         w_err_at;

`ifdef MMIO_TIMEOUT_EN
    localparam int C_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [C_CNT_W-1:0]  r_cnt, w_cnt_d;
`endif

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                w_req;
    logic                w_periph;
    logic [11:0]         w_off;
    logic [9:0]          w_idx_full;
    logic                w_mapped;
    logic [N_SLOTS-1:0]  w_onehot;
    logic                w_ready_sel;
    logic [DATA_W-1:0]   w_rdata_sel;

    assign w_req      = bus.we | bus.re;
    assign w_periph   = bus.addr[PERIPH_BIT];
    assign w_off      = bus.addr[11:0] - BASE_OFF;
    assign w_idx_full = w_off[11:2];
    // The >= BASE_OFF term rejects offsets that wrapped in the subtraction.
    assign w_mapped   = w_periph && (bus.addr[1:0] == 2'b00) &&
                        (bus.addr[11:0] >= BASE_OFF) &&
                        (w_idx_full < 10'(N_SLOTS));

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_onehot[i] = (w_idx_full == 10'(i));
        end
    end

    // Only the slot owning the in-flight access can complete it.
    assign w_ready_sel = bus.slot_ready[r_idx];
    assign w_rdata_sel = bus.slot_rdata[r_idx*DATA_W +: DATA_W];

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state;
        w_idx_d      = r_idx;
        w_addr_d     = r_addr;
        w_wdata_d    = r_wdata;
        w_wr_d       = r_wr;
        w_slot_we_d  = r_slot_we;
        w_slot_re_d  = r_slot_re;
        w_rdata_d    = r_rdata;
        w_bus_err_d  = r_bus_err;
        w_err_addr_d = r_err_addr;
        w_stall      = 1'b0;
        w_err_evt    = 1'b0;
        w_err_at     = 32'd0;
`ifdef MMIO_TIMEOUT_EN
        w_cnt_d      = r_cnt;
`endif

        if (bus.err_clr) begin
            w_bus_err_d  = 1'b0;
            w_err_addr_d = 32'd0;
        end

        case (r_state)
            ST_IDLE: begin
                w_stall = w_req && w_periph;
                if (w_req && w_periph) begin
                    if (w_mapped) begin
                        w_idx_d   = w_idx_full[C_IDX_W-1:0];
                        w_addr_d  = bus.addr;
                        w_wdata_d = bus.wdata;
                        w_wr_d    = bus.we;   // store wins over load
                        if (bus.we) begin
                            w_slot_we_d = w_onehot;
                        end else begin
                            w_slot_re_d = w_onehot;
                        end
`ifdef MMIO_TIMEOUT_EN
                        w_cnt_d   = '0;
`endif
                        w_state_d = ST_WAIT;
                    end else begin
                        w_rdata_d = ERR_DATA;
                        w_err_evt = 1'b1;
                        w_err_at  = bus.addr;
                        w_state_d = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                w_stall = 1'b1;
                if (w_ready_sel) begin
                    if (!r_wr) begin
                        w_rdata_d = w_rdata_sel;
                    end
                    w_slot_we_d = '0;
                    w_slot_re_d = '0;
                    w_state_d   = ST_DONE;
                end
`ifdef MMIO_TIMEOUT_EN
                // This cycle would bring the count to TIMEOUT: abort.
                else if (r_cnt == C_CNT_W'(TIMEOUT - 1)) begin
                    w_slot_we_d = '0;
                    w_slot_re_d = '0;
                    w_rdata_d   = ERR_DATA;
                    w_err_evt   = 1'b1;
                    w_err_at    = r_addr;
                    w_state_d   = ST_DONE;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                // The CPU sees its result now; the still-present request is
                // the completing one and must not be re-issued.
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // A new error overrides a simultaneous clear.
        if (w_err_evt) begin
            w_bus_err_d = 1'b1;
            if (!r_bus_err || bus.err_clr) begin
                w_err_addr_d = w_err_at;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_addr     <= 32'd0;
            r_wdata    <= '0;
            r_wr       <= 1'b0;
            r_slot_we  <= '0;
            r_slot_re  <= '0;
            r_rdata    <= '0;
            r_bus_err  <= 1'b0;
            r_err_addr <= 32'd0;
`ifdef MMIO_TIMEOUT_EN
            r_cnt      <= '0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_idx      <= w_idx_d;
            r_addr     <= w_addr_d;
            r_wdata    <= w_wdata_d;
            r_wr       <= w_wr_d;
            r_slot_we  <= w_slot_we_d;
            r_slot_re  <= w_slot_re_d;
            r_rdata    <= w_rdata_d;
            r_bus_err  <= w_bus_err_d;
            r_err_addr <= w_err_addr_d;
`ifdef MMIO_TIMEOUT_EN
            r_cnt      <= w_cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.dmem_we    = bus.we & ~w_periph;
    assign bus.rdata      = w_periph ? r_rdata : bus.dmem_rdata;
    assign bus.stall      = w_stall;
    assign bus.slot_we    = r_slot_we;
    assign bus.slot_re    = r_slot_re;
    assign bus.slot_addr  = r_addr[11:0];
    assign bus.slot_wdata = r_wdata;
    assign bus.bus_err    = r_bus_err;
    assign bus.err_addr   = r_err_addr;

    // Bits that carry no information in this configuration.
    logic unused_bits;
`ifdef MMIO_TIMEOUT_EN
    assign unused_bits = ^w_off[1:0];
`else
    assign unused_bits = ^{w_off[1:0], r_addr[31:12], (TIMEOUT != 0)};
`endif

endmodule
`default_nettype wire
